// File: rtl/mc_pkg.sv
// Shared constants, state encoding and control-word layout for the multi-cycle MIPS controller.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_J       = 6'b000010;

    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    localparam int SYS_PRINT_INT = 1;
    localparam int SYS_READ_INT  = 5;
    localparam int SYS_EXIT      = 10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] WD_ALUOUT    = 2'b00;
    localparam logic [1:0] WD_MDR       = 2'b01;
    localparam logic [1:0] WD_IO        = 2'b10;

    localparam logic SRCA_PC   = 1'b0;
    localparam logic SRCA_A    = 1'b1;
    localparam logic IORD_PC   = 1'b0;
    localparam logic IORD_ALU  = 1'b1;
    localparam logic REGDST_RT = 1'b0;
    localparam logic REGDST_RD = 1'b1;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_R_WB    = 4'd3,
        S_EX_I    = 4'd4,
        S_I_WB    = 4'd5,
        S_MEM_ADR = 4'd6,
        S_MEM_RD  = 4'd7,
        S_MEM_WB  = 4'd8,
        S_MEM_WR  = 4'd9,
        S_BEQ     = 4'd10,
        S_JMP     = 4'd11,
        S_SYS     = 4'd12,
        S_SYS_OUT = 4'd13,
        S_SYS_IN  = 4'd14,
        S_HALT    = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halt;
        logic       io_in_ready;
        logic       io_out_valid;
    } ctl_t;

endpackage

// File: rtl/mc_control_decode.sv
// Pure Moore decode: current state to datapath control word, no handshake gating here.
module mc_control_decode
    import mc_pkg::*;
(
    input  state_t state,
    output ctl_t   ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            S_IF: begin
                ctl.mem_read  = 1'b1;
                ctl.ir_write  = 1'b1;
                ctl.pc_write  = 1'b1;
                ctl.iord      = IORD_PC;
                ctl.alu_src_a = SRCA_PC;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_source = PCSRC_ALU;
            end
            S_ID: begin
                ctl.alu_src_a = SRCA_PC;
                ctl.alu_src_b = SRCB_IMM_SH2;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_EX_R: begin
                ctl.alu_src_a = SRCA_A;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctl.reg_dst    = REGDST_RD;
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = WD_ALUOUT;
            end
            S_EX_I, S_MEM_ADR: begin
                ctl.alu_src_a = SRCA_A;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_I_WB: begin
                ctl.reg_dst    = REGDST_RT;
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = WD_ALUOUT;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = IORD_ALU;
            end
            S_MEM_WB: begin
                ctl.reg_dst    = REGDST_RT;
                ctl.mem_to_reg = WD_MDR;
                ctl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = IORD_ALU;
            end
            S_BEQ: begin
                ctl.alu_src_a     = SRCA_A;
                ctl.alu_src_b     = SRCB_B;
                ctl.alu_op        = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
            end
            S_JMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
            end
            S_SYS_OUT: ctl.io_out_valid = 1'b1;
            S_SYS_IN:  ctl.io_in_ready  = 1'b1;
            S_HALT:    ctl.halt         = 1'b1;
            default:   ctl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: state register, instruction dispatch and console I/O handshake.
// Syscall I/O (SYS/SYS_IN/SYS_OUT/HALT) is built only when SYSCALL_IO_EN is defined.
module mc_control
    import mc_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int V0_W = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    input  logic [V0_W-1:0] v0,
    input  logic            zero,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic [1:0]      mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic            halt,
    output logic [3:0]      state
);

    state_t cur_state;
    state_t nxt_state;
    ctl_t   dec;
    ctl_t   ctl;
    logic   is_rtype;

    assign is_rtype = (opcode == OP_W'(OP_RTYPE));

    always_ff @(posedge clk) begin
        if (rst) cur_state <= S_IF;
        else     cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = S_IF;
        case (cur_state)
            S_IF:      nxt_state = S_ID;
            S_ID: begin
                if (is_rtype && funct == OP_W'(FN_ADD))           nxt_state = S_EX_R;
`ifdef SYSCALL_IO_EN
                else if (is_rtype && funct == OP_W'(FN_SYSCALL))  nxt_state = S_SYS;
`endif
                else if (opcode == OP_W'(OP_ADDI))                nxt_state = S_EX_I;
                else if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW))
                                                                  nxt_state = S_MEM_ADR;
                else if (opcode == OP_W'(OP_BEQ))                 nxt_state = S_BEQ;
                else if (opcode == OP_W'(OP_J))                   nxt_state = S_JMP;
                else                                              nxt_state = S_IF;
            end
            S_EX_R:    nxt_state = S_R_WB;
            S_EX_I:    nxt_state = S_I_WB;
            S_MEM_ADR: nxt_state = (opcode == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  nxt_state = S_MEM_WB;
`ifdef SYSCALL_IO_EN
            S_SYS: begin
                if (v0 == V0_W'(SYS_PRINT_INT))      nxt_state = S_SYS_OUT;
                else if (v0 == V0_W'(SYS_READ_INT))  nxt_state = S_SYS_IN;
                else if (v0 == V0_W'(SYS_EXIT))      nxt_state = S_HALT;
                else                                 nxt_state = S_IF;
            end
            S_SYS_OUT: nxt_state = io_out_ready ? S_IF : S_SYS_OUT;
            S_SYS_IN:  nxt_state = io_in_valid  ? S_IF : S_SYS_IN;
            S_HALT:    nxt_state = S_HALT;
`endif
            default:   nxt_state = S_IF;
        endcase
    end

    mc_control_decode u_decode (
        .state (cur_state),
        .ctl   (dec)
    );

    // The input word is written to $v0 only in the cycle the device offers it.
    always_comb begin
        ctl = dec;
`ifdef SYSCALL_IO_EN
        if (cur_state == S_SYS_IN && io_in_valid) begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = WD_IO;
        end
`else
        ctl.halt         = 1'b0;
        ctl.io_in_ready  = 1'b0;
        ctl.io_out_valid = 1'b0;
`endif
        if (rst) ctl = '0;
    end

    // The zero flag gates PC load in the datapath, not here.
`ifdef SYSCALL_IO_EN
    logic unused_inputs;
    assign unused_inputs = zero;
`else
    logic unused_inputs;
    assign unused_inputs = ^{zero, v0, io_in_valid, io_out_ready};
`endif

    assign pc_write      = ctl.pc_write;
    assign pc_write_cond = ctl.pc_write_cond;
    assign iord          = ctl.iord;
    assign mem_read      = ctl.mem_read;
    assign mem_write     = ctl.mem_write;
    assign ir_write      = ctl.ir_write;
    assign reg_dst       = ctl.reg_dst;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign reg_write     = ctl.reg_write;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign alu_op        = ctl.alu_op;
    assign pc_source     = ctl.pc_source;
    assign halt          = ctl.halt;
    assign io_in_ready   = ctl.io_in_ready;
    assign io_out_valid  = ctl.io_out_valid;
    assign state         = rst ? 4'd0 : cur_state;

endmodule
